// File: rtl/mul_hilo_seq_if.sv
// Operand/product/handshake bundle between the control unit, the HI/LO
// multiply sequencer and the combinational Booth multiplier.
interface mul_hilo_seq_if #(
    parameter int WIDTH = 32
);
    logic               start;
    logic [WIDTH-1:0]   a_in;
    logic [WIDTH-1:0]   b_in;
    logic [WIDTH-1:0]   x_out;
    logic [WIDTH-1:0]   y_out;
    logic [2*WIDTH-1:0] zin;
    logic               busy;
    logic               done;
    logic [WIDTH-1:0]   hi_out;
    logic [WIDTH-1:0]   lo_out;
    logic               ovf;

    modport slave (
        input  start, a_in, b_in, zin,
        output x_out, y_out, busy, done, hi_out, lo_out, ovf
    );

    modport master (
        output start, a_in, b_in, zin,
        input  x_out, y_out, busy, done, hi_out, lo_out, ovf
    );
endinterface

// File: rtl/mul_hilo_seq.sv
// Multicycle sequencer around the combinational signed multiplier: latches
// operands, waits a settle window, then captures the product into HI/LO.
module mul_hilo_seq #(
    parameter int WIDTH         = 32,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic           clock,
    input  logic           clear,
    mul_hilo_seq_if.slave  bus
);

    // A settle window of zero still needs one edge for the multiplier output to be valid.
    localparam int EFF_SETTLE = (SETTLE_CYCLES < 1) ? 1 : SETTLE_CYCLES;
    localparam int CNT_W      = (EFF_SETTLE > 1) ? $clog2(EFF_SETTLE) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(EFF_SETTLE - 1);

    typedef enum logic {IDLE, SETTLE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] x_q, x_d;
    logic [WIDTH-1:0] y_q, y_d;
    logic [WIDTH-1:0] hi_q, hi_d;
    logic [WIDTH-1:0] lo_q, lo_d;
    logic             done_q, done_d;
    logic             ovf_q, ovf_d;

    logic             zeroOperand;
    logic             prodOvf;

    assign zeroOperand = (bus.a_in == '0) || (bus.b_in == '0);
    // Product fits in WIDTH signed bits only if the upper half is pure sign extension.
    assign prodOvf     = (bus.zin[2*WIDTH-1:WIDTH] != {WIDTH{bus.zin[WIDTH-1]}});

    always_ff @(posedge clock) begin
        if (!clear) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            x_q     <= '0;
            y_q     <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            done_q  <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            x_q     <= x_d;
            y_q     <= y_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            done_q  <= done_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        x_d     = x_q;
        y_d     = y_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        ovf_d   = ovf_q;

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    x_d = bus.a_in;
                    y_d = bus.b_in;
                    // A zero operand has a known product, so skip the settle window.
                    if (zeroOperand) begin
                        hi_d   = '0;
                        lo_d   = '0;
                        ovf_d  = 1'b0;
                        done_d = 1'b1;
                    end else begin
                        cnt_d   = CNT_LOAD;
                        state_d = SETTLE;
                    end
                end
            end
            SETTLE: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    hi_d    = bus.zin[2*WIDTH-1:WIDTH];
                    lo_d    = bus.zin[WIDTH-1:0];
                    ovf_d   = prodOvf;
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.x_out  = x_q;
    assign bus.y_out  = y_q;
    assign bus.busy   = (state_q == SETTLE);
    assign bus.done   = done_q;
    assign bus.hi_out = hi_q;
    assign bus.lo_out = lo_q;
    assign bus.ovf    = ovf_q;

endmodule

// File: tb/tb_mul_hilo_seq.sv
// Self-checking bench for mul_hilo_seq: vector table, random operands against
// a signed-arithmetic reference, and hand-written handshake/reset sequences.
module tb_mul_hilo_seq;

    localparam int W = 32;

    logic clock;
    logic clear;
    int   nCompared;
    int   nMismatched;

    mul_hilo_seq_if #(.WIDTH(W)) bus ();

    mul_hilo_seq #(.WIDTH(W), .SETTLE_CYCLES(2)) dut (
        .clock (clock),
        .clear (clear),
        .bus   (bus)
    );

    // Stand-in for the combinational Booth multiplier.
    logic signed [2*W-1:0] xExt, yExt;
    assign xExt    = {{W{bus.x_out[W-1]}}, bus.x_out};
    assign yExt    = {{W{bus.y_out[W-1]}}, bus.y_out};
    assign bus.zin = xExt * yExt;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    typedef struct {
        string       name;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi;
        logic [31:0] lo;
        logic        ovf;
    } vec_t;

    vec_t vecs[9];

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    function automatic void refModel(input logic [31:0] a, input logic [31:0] b,
                                     output logic [31:0] hi, output logic [31:0] lo,
                                     output logic ovf);
        longint p;
        longint maxV;
        longint minV;
        maxV = 64'sh0000_0000_7FFF_FFFF;
        minV = -maxV - 1;
        p    = longint'($signed(a)) * longint'($signed(b));
        hi   = p[63:32];
        lo   = p[31:0];
        ovf  = (p > maxV) || (p < minV);
    endfunction

    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] b);
        @(negedge clock);
        bus.start = 1'b1;
        bus.a_in  = a;
        bus.b_in  = b;
        @(negedge clock);
        bus.start = 1'b0;
    endtask

    task automatic runAndCheck(input string tag, input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] expHi, input logic [31:0] expLo, input logic expOvf);
        int busyCycles;
        int waitCycles;
        int expLat;
        busyCycles = 0;
        waitCycles = 0;
        expLat     = ((a == 0) || (b == 0)) ? 0 : 2;
        applyStimulus(a, b);
        while (!bus.done && waitCycles < 20) begin
            if (bus.busy) busyCycles++;
            @(negedge clock);
            waitCycles++;
        end
        checkOutput({tag, "_done"},    64'(bus.done),   64'd1);
        checkOutput({tag, "_latency"}, 64'(waitCycles), 64'(expLat));
        checkOutput({tag, "_busy"},    64'(busyCycles), 64'(expLat));
        checkOutput({tag, "_hi"},      64'(bus.hi_out), 64'(expHi));
        checkOutput({tag, "_lo"},      64'(bus.lo_out), 64'(expLo));
        checkOutput({tag, "_ovf"},     64'(bus.ovf),    64'(expOvf));
        checkOutput({tag, "_x"},       64'(bus.x_out),  64'(a));
        checkOutput({tag, "_y"},       64'(bus.y_out),  64'(b));
        @(negedge clock);
        checkOutput({tag, "_donePulse"}, 64'(bus.done), 64'd0);
    endtask

    initial begin
        logic [31:0] ra, rb, mHi, mLo;
        logic        mOvf;
        int          donePulses;

        nCompared   = 0;
        nMismatched = 0;

        vecs[0] = '{"neg",      32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
        vecs[1] = '{"minsq",    32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b1};
        vecs[2] = '{"smallovf", 32'h0001_0000,  32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b1};
        vecs[3] = '{"maxsq",    32'h7FFF_FFFF,  32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b1};
        vecs[4] = '{"m1m1",     32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};
        vecs[5] = '{"fitpos",   32'h0001_0000,  32'h0000_7FFF, 32'h0000_0000, 32'h7FFF_0000, 1'b0};
        vecs[6] = '{"fitmin",   32'hFFFF_0000,  32'h0000_8000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0};
        vecs[7] = '{"justovf",  32'h0000_8000,  32'h0001_0000, 32'h0000_0000, 32'h8000_0000, 1'b1};
        vecs[8] = '{"small",    32'd12,         32'd11,        32'h0000_0000, 32'd132,       1'b0};

        // Reset with start asserted: reset must win.
        clear     = 1'b0;
        bus.start = 1'b1;
        bus.a_in  = 32'd5;
        bus.b_in  = 32'd5;
        repeat (2) @(negedge clock);
        checkOutput("rst_x",    64'(bus.x_out),  64'd0);
        checkOutput("rst_y",    64'(bus.y_out),  64'd0);
        checkOutput("rst_hi",   64'(bus.hi_out), 64'd0);
        checkOutput("rst_lo",   64'(bus.lo_out), 64'd0);
        checkOutput("rst_busy", 64'(bus.busy),   64'd0);
        checkOutput("rst_done", 64'(bus.done),   64'd0);
        checkOutput("rst_ovf",  64'(bus.ovf),    64'd0);
        bus.start = 1'b0;
        clear     = 1'b1;
        @(negedge clock);

        for (int i = 0; i < 9; i++) begin
            runAndCheck(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].hi, vecs[i].lo, vecs[i].ovf);
        end

        // Fast path after a nonzero result.
        runAndCheck("fast", 32'd0, 32'h1234, 32'd0, 32'd0, 1'b0);

        // Start during SETTLE is ignored; start in the done cycle is accepted.
        @(negedge clock);
        bus.start = 1'b1; bus.a_in = 32'd5; bus.b_in = 32'd6;
        @(negedge clock);
        bus.a_in = 32'd9; bus.b_in = 32'd9;
        @(negedge clock);
        bus.start = 1'b0;
        @(negedge clock);
        checkOutput("ign_done", 64'(bus.done),   64'd1);
        checkOutput("ign_lo",   64'(bus.lo_out), 64'd30);
        checkOutput("ign_x",    64'(bus.x_out),  64'd5);
        bus.start = 1'b1; bus.a_in = 32'd2; bus.b_in = 32'd3;
        @(negedge clock);
        bus.start = 1'b0;
        checkOutput("b2b_busy1", 64'(bus.busy),   64'd1);
        checkOutput("b2b_x",     64'(bus.x_out),  64'd2);
        checkOutput("b2b_lo1",   64'(bus.lo_out), 64'd30);
        @(negedge clock);
        checkOutput("b2b_lo2",   64'(bus.lo_out), 64'd30);
        checkOutput("b2b_done2", 64'(bus.done),   64'd0);
        @(negedge clock);
        checkOutput("b2b_done",  64'(bus.done),   64'd1);
        checkOutput("b2b_lo",    64'(bus.lo_out), 64'd6);

        // Reset in the middle of SETTLE aborts the operation.
        @(negedge clock);
        bus.start = 1'b1; bus.a_in = 32'd100; bus.b_in = 32'd100;
        @(negedge clock);
        bus.start = 1'b0;
        clear     = 1'b0;
        @(negedge clock);
        clear = 1'b1;
        checkOutput("abort_busy", 64'(bus.busy),   64'd0);
        checkOutput("abort_x",    64'(bus.x_out),  64'd0);
        checkOutput("abort_lo",   64'(bus.lo_out), 64'd0);
        checkOutput("abort_hi",   64'(bus.hi_out), 64'd0);
        donePulses = 0;
        for (int i = 0; i < 4; i++) begin
            if (bus.done) donePulses++;
            @(negedge clock);
        end
        checkOutput("abort_nodone", 64'(donePulses),  64'd0);
        checkOutput("abort_lo_late", 64'(bus.lo_out), 64'd0);
        runAndCheck("post", 32'd4, 32'd4, 32'd0, 32'd16, 1'b0);

        // Random operands, with occasional zero and extreme values.
        for (int i = 0; i < 40; i++) begin
            ra = $urandom;
            rb = $urandom;
            case ($urandom_range(0, 7))
                0: ra = 32'd0;
                1: rb = 32'd0;
                2: ra = ra >>> $urandom_range(0, 31);
                3: rb = 32'h8000_0000;
                default: ;
            endcase
            refModel(ra, rb, mHi, mLo, mOvf);
            runAndCheck($sformatf("rnd%0d", i), ra, rb, mHi, mLo, mOvf);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/mul_hilo_seq.md
Name: mul_hilo_seq

Overview:
Multicycle sequencer that wraps the combinational 32x32 signed Booth multiplier. It registers the operands and drives them onto the multiplier's X/Y inputs. It then holds them stable for a programmable number of settle cycles and captures the 64-bit product into HI/LO registers, with a start/busy/done handshake toward the control unit. It sits between the datapath bus, which supplies the operands, and the multiplier plus the HI/LO read path.

Parameters:
WIDTH, 32, operand width; product is 2*WIDTH.
SETTLE_CYCLES, 2, clock edges the operands are held before product capture; a value of 0 is treated as 1.

Ports:
clock  input  1  system clock; all state updates on its rising edge
clear  input  1  synchronous, active-low reset
start  input  1  request a multiply; sampled only in IDLE
a_in  input  WIDTH  multiplicand (signed), sampled with start
b_in  input  WIDTH  multiplier (signed), sampled with start
x_out  output  WIDTH  registered operand to multiplier X
y_out  output  WIDTH  registered operand to multiplier Y
zin  input  2*WIDTH  combinational product returned from multiplier
busy  output  1  high while in SETTLE
done  output  1  one-cycle pulse after HI/LO are written
hi_out  output  WIDTH  HI register (product[63:32])
lo_out  output  WIDTH  LO register (product[31:0])
ovf  output  1  registered; product does not fit in WIDTH signed bits

Behaviour:
- Reset (clear=0 at an edge): state=IDLE; x_out, y_out, hi_out, lo_out = 0; busy=0, done=0, ovf=0; counter=0. Reset overrides every other input.
- Reset mid-SETTLE aborts the operation: no capture, no done pulse.
- States: IDLE, SETTLE. busy is a registered output equal to (state==SETTLE). done defaults to 0 at every edge unless a capture occurs on that edge.
- IDLE, start=1, both operands nonzero: x_out<=a_in, y_out<=b_in, cnt<=SETTLE_CYCLES-1, state<=SETTLE.
- IDLE, start=1, a_in==0 or b_in==0 (fast path):
  - x_out, y_out loaded as normal.
  - Same edge: hi_out<=0, lo_out<=0, ovf<=0, done<=1.
  - State stays IDLE; busy never asserts.
- IDLE, start=0: hold all registers.
- SETTLE, cnt!=0: cnt<=cnt-1. Operands held.
- SETTLE, cnt==0 (capture edge):
  - hi_out<=zin[63:32], lo_out<=zin[31:0].
  - ovf<=(zin[63:32] != {WIDTH{zin[31]}}).
  - done<=1, state<=IDLE.
- Latency: start sampled at edge E0. Capture occurs at edge E(SETTLE_CYCLES). done is high for exactly the cycle following the capture edge. Default: capture at E2.
- start while in SETTLE is ignored; no queueing.
- start high in the cycle done is high (state IDLE) is accepted, so back-to-back operations are legal. HI/LO keep the previous result until the new capture edge.
- x_out/y_out hold their value until the next accepted start; HI/LO hold until the next capture, fast path, or reset.
- All arithmetic is two's complement. The block performs no arithmetic itself apart from the ovf compare.

Test Plan:
- Normal multiply: reset, then start with a_in=7, b_in=-3 (0xFFFFFFFD) -> busy=1 for 2 cycles; at E2 hi_out=0xFFFFFFFF, lo_out=0xFFFFFFEB, ovf=0; done=1 for one cycle only.
- Overflow, large operands: a_in=b_in=0x80000000 -> hi_out=0x40000000, lo_out=0x00000000, ovf=1.
- Overflow, small operands: a_in=b_in=0x00010000 -> hi_out=0x00000001, lo_out=0, ovf=1.
- Fast path: after a prior nonzero result, start with a_in=0, b_in=0x1234 -> done=1 in the cycle after E0; hi_out=lo_out=0, ovf=0; busy stays 0; y_out=0x1234.
- Handshake and back-to-back:
  - Start 5x6, then pulse start with 9x9 during SETTLE -> ignored; result is lo_out=30.
  - Then assert start with 2x3 in the done cycle -> accepted; lo_out stays 30 until the new capture, then becomes 6.
- Reset mid-operation: start 100x100, drive clear=0 at E1 -> at E2 all outputs are 0, done never pulses, state IDLE; a following start 4x4 yields lo_out=16 normally.
